// File: rtl/lap_ctrl.sv
// lap_ctrl: lap capture ring, display hold/browse sequencing, LCM handoff.
// Optional browse of stored laps is compiled in with LAP_BROWSE_EN.
module lap_ctrl #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        lap,
  input  logic        clear,
  input  logic        run,
  input  logic [5:0]  hour,
  input  logic [5:0]  minute,
  input  logic [5:0]  second,
  input  logic [6:0]  m_sec,
  output logic [5:0]  disp_hour,
  output logic [5:0]  disp_minute,
  output logic [5:0]  disp_second,
  output logic [6:0]  disp_m_sec,
  output logic        lap_mode,
  output logic [6:0]  lap_count,
  output logic [6:0]  lap_total,
  output logic        upd_req,
  output logic [24:0] upd_data,
  output logic [6:0]  upd_slot,
  input  logic        upd_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES);

`ifdef LAP_BROWSE_EN
  typedef enum logic [1:0] {LIVE, HOLD, BROWSE} state_t;
`else
  typedef enum logic [1:0] {LIVE, HOLD} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr;
  logic [24:0]   disp_q, disp_d;
  logic [24:0]   lap_buf [DEPTH];
  logic          lap_q, clear_q;
  logic          lap_rise, clr_rise, capture;
  logic [24:0]   live;
  logic [6:0]    total_nx;

`ifdef LAP_BROWSE_EN
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] rd_ptr;
`endif

  assign live     = {hour, minute, second, m_sec};
  assign lap_rise = lap & ~lap_q;
  assign clr_rise = clear & ~clear_q;
  assign total_nx = (lap_total == 7'd99) ? 7'd99 : lap_total + 7'd1;
  assign lap_mode = (state_q != LIVE);

  assign disp_hour   = disp_q[24:19];
  assign disp_minute = disp_q[18:13];
  assign disp_second = disp_q[12:7];
  assign disp_m_sec  = disp_q[6:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
`ifdef LAP_BROWSE_EN
    idx_d   = idx_q;
`endif
    if (clr_rise) begin
      state_d = LIVE;
    end else begin
      unique case (state_q)
        LIVE: begin
          if (lap_rise && run) begin
            capture = 1'b1;
            state_d = HOLD;
            cnt_d   = CW'(HOLD_CYCLES - 1);
`ifdef LAP_BROWSE_EN
          end else if (lap_rise && lap_count != 7'd0) begin
            state_d = BROWSE;
            idx_d   = '0;
`endif
          end
        end
        HOLD: begin
          if (lap_rise && run) begin
            capture = 1'b1;
            cnt_d   = CW'(HOLD_CYCLES - 1);
          end else if (cnt_q == '0) begin
            state_d = LIVE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`ifdef LAP_BROWSE_EN
        BROWSE: begin
          if (run) begin
            state_d = LIVE;
          end else if (lap_rise) begin
            if (7'(idx_q) == lap_count - 7'd1) state_d = LIVE;
            else idx_d = idx_q + PW'(1);
          end
        end
`endif
        default: state_d = LIVE;
      endcase
    end
  end

`ifdef LAP_BROWSE_EN
  // Index 0 is the newest entry, one slot behind the write pointer.
  assign rd_ptr = wr_ptr - PW'(1) - idx_d;
`endif

  always_comb begin
    disp_d = live;
    unique case (state_d)
      LIVE: disp_d = live;
      HOLD: disp_d = capture ? live : disp_q;
`ifdef LAP_BROWSE_EN
      BROWSE: disp_d = lap_buf[rd_ptr];
`endif
      default: disp_d = live;
    endcase
  end

  always_ff @(posedge clock) begin
    if (capture) lap_buf[wr_ptr] <= live;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LIVE;
      cnt_q     <= '0;
      wr_ptr    <= '0;
      disp_q    <= '0;
      lap_q     <= 1'b0;
      clear_q   <= 1'b0;
      lap_count <= '0;
      lap_total <= '0;
      upd_req   <= 1'b0;
      upd_data  <= '0;
      upd_slot  <= '0;
`ifdef LAP_BROWSE_EN
      idx_q     <= '0;
`endif
    end else begin
      lap_q   <= lap;
      clear_q <= clear;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
`ifdef LAP_BROWSE_EN
      idx_q   <= idx_d;
`endif
      if (clr_rise) begin
        wr_ptr    <= '0;
        lap_count <= '0;
        lap_total <= '0;
        upd_req   <= 1'b0;
        upd_data  <= '0;
        upd_slot  <= '0;
      end else if (capture) begin
        wr_ptr    <= wr_ptr + PW'(1);
        if (lap_count != 7'(DEPTH)) lap_count <= lap_count + 7'd1;
        lap_total <= total_nx;
        upd_req   <= 1'b1;
        upd_data  <= live;
        upd_slot  <= total_nx;
      end else if (upd_ack) begin
        upd_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lap_ctrl.sv
// tb_lap_ctrl: directed checks of lap_ctrl with DEPTH=4, HOLD_CYCLES=10.
// Browse checks follow LAP_BROWSE_EN.
module tb_lap_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        lap = 1'b0, clear = 1'b0, run = 1'b0, upd_ack = 1'b0;
  logic [5:0]  hour = '0, minute = '0, second = '0;
  logic [6:0]  m_sec = '0;
  logic [5:0]  disp_hour, disp_minute, disp_second;
  logic [6:0]  disp_m_sec;
  logic        lap_mode, upd_req;
  logic [6:0]  lap_count, lap_total, upd_slot;
  logic [24:0] upd_data;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [24:0] T1 = {6'd0, 6'd1, 6'd2, 7'd34};
  localparam logic [24:0] L2 = {6'd0, 6'd1, 6'd3, 7'd0};
  localparam logic [24:0] T2 = {6'd0, 6'd2, 6'd5, 7'd11};
  localparam logic [24:0] T3 = {6'd0, 6'd3, 6'd10, 7'd22};
  localparam logic [24:0] T4 = {6'd0, 6'd4, 6'd15, 7'd33};
  localparam logic [24:0] T5 = {6'd1, 6'd5, 6'd20, 7'd44};
  localparam logic [24:0] T6 = {6'd2, 6'd6, 6'd25, 7'd99};
  localparam logic [24:0] LV = {6'd3, 6'd0, 6'd0, 7'd0};

  lap_ctrl #(.DEPTH(4), .HOLD_CYCLES(10)) dut (
    .clock(clock), .reset_n(reset_n), .lap(lap), .clear(clear),
    .run(run), .hour(hour), .minute(minute), .second(second),
    .m_sec(m_sec), .disp_hour(disp_hour), .disp_minute(disp_minute),
    .disp_second(disp_second), .disp_m_sec(disp_m_sec),
    .lap_mode(lap_mode), .lap_count(lap_count), .lap_total(lap_total),
    .upd_req(upd_req), .upd_data(upd_data), .upd_slot(upd_slot),
    .upd_ack(upd_ack)
  );

  always #5 clock = ~clock;

  wire [24:0] disp = {disp_hour, disp_minute, disp_second, disp_m_sec};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_w(input logic [24:0] w);
    {hour, minute, second, m_sec} = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input logic [24:0] w);
    set_w(w);
    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
  endtask

  initial begin
    logic [24:0] bexp [4];
    bexp = '{T6, T5, T4, T3};

    #1 reset_n = 1'b0;
    #2;
    chk("rst_mode", 32'(lap_mode), 32'd0);
    chk("rst_count", 32'(lap_count), 32'd0);
    chk("rst_total", 32'(lap_total), 32'd0);
    chk("rst_req", 32'(upd_req), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    run = 1'b1;
    set_w(T1);
    tick();
    chk("live_pass", 32'(disp), 32'(T1));
    lap = 1'b1;
    tick();
    lap = 1'b0;
    set_w(L2);
    chk("cap_disp", 32'(disp), 32'(T1));
    chk("cap_mode", 32'(lap_mode), 32'd1);
    chk("cap_req", 32'(upd_req), 32'd1);
    chk("cap_slot", 32'(upd_slot), 32'd1);
    chk("cap_data", 32'(upd_data), 32'(T1));
    chk("cap_count", 32'(lap_count), 32'd1);
    chk("cap_total", 32'(lap_total), 32'd1);
    repeat (4) tick();
    chk("req_held", 32'(upd_req), 32'd1);
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    chk("ack_drop", 32'(upd_req), 32'd0);
    repeat (4) tick();
    chk("hold_last_mode", 32'(lap_mode), 32'd1);
    chk("hold_last_disp", 32'(disp), 32'(T1));
    tick();
    chk("hold_end_mode", 32'(lap_mode), 32'd0);
    chk("hold_end_disp", 32'(disp), 32'(L2));

    cap(T2);
    cap(T3);
    chk("pend_req", 32'(upd_req), 32'd1);
    chk("pend_slot", 32'(upd_slot), 32'd3);
    chk("pend_data", 32'(upd_data), 32'(T3));
    chk("pend_disp", 32'(disp), 32'(T3));
    chk("pend_count", 32'(lap_count), 32'd3);
    upd_ack = 1'b1;
    tick();
    upd_ack = 1'b0;
    chk("pend_ack", 32'(upd_req), 32'd0);
    cap(T4);
    chk("t4_req", 32'(upd_req), 32'd1);
    set_w(T5);
    lap = 1'b1;
    upd_ack = 1'b1;
    tick();
    lap = 1'b0;
    upd_ack = 1'b0;
    chk("cap_ack_req", 32'(upd_req), 32'd1);
    chk("cap_ack_data", 32'(upd_data), 32'(T5));
    chk("cap_ack_slot", 32'(upd_slot), 32'd5);
    tick();
    cap(T6);
    chk("ovf_count", 32'(lap_count), 32'd4);
    chk("ovf_total", 32'(lap_total), 32'd6);
    chk("ovf_slot", 32'(upd_slot), 32'd6);

    run = 1'b0;
    set_w(LV);
    repeat (12) tick();
    chk("idle_mode", 32'(lap_mode), 32'd0);
    chk("idle_disp", 32'(disp), 32'(LV));
`ifdef LAP_BROWSE_EN
    for (int i = 0; i < 4; i++) begin
      lap = 1'b1;
      tick();
      lap = 1'b0;
      chk($sformatf("brw_disp%0d", i), 32'(disp), 32'(bexp[i]));
      chk($sformatf("brw_mode%0d", i), 32'(lap_mode), 32'd1);
      tick();
    end
    lap = 1'b1;
    tick();
    lap = 1'b0;
    chk("brw_exit_mode", 32'(lap_mode), 32'd0);
    chk("brw_exit_disp", 32'(disp), 32'(LV));
    tick();
    lap = 1'b1;
    tick();
    lap = 1'b0;
    chk("brw_re_disp", 32'(disp), 32'(T6));
    tick();
    run = 1'b1;
    tick();
    chk("brw_run_exit", 32'(lap_mode), 32'd0);
`else
    lap = 1'b1;
    tick();
    lap = 1'b0;
    chk("nobrw_mode", 32'(lap_mode), 32'd0);
    chk("nobrw_disp", 32'(disp), 32'(LV));
    chk("nobrw_count", 32'(lap_count), 32'd4);
    tick();
    run = 1'b1;
    tick();
`endif

    cap(T1);
    chk("pre_clr_mode", 32'(lap_mode), 32'd1);
    clear = 1'b1;
    lap = 1'b1;
    tick();
    clear = 1'b0;
    lap = 1'b0;
    chk("clr_mode", 32'(lap_mode), 32'd0);
    chk("clr_count", 32'(lap_count), 32'd0);
    chk("clr_total", 32'(lap_total), 32'd0);
    chk("clr_req", 32'(upd_req), 32'd0);
    chk("clr_disp", 32'(disp), 32'(T1));
    tick();

    for (int i = 0; i < 100; i++) cap(T2);
    chk("sat_total", 32'(lap_total), 32'd99);
    chk("sat_slot", 32'(upd_slot), 32'd99);
    chk("sat_count", 32'(lap_count), 32'd4);

    chk("pre_rst_mode", 32'(lap_mode), 32'd1);
    chk("pre_rst_req", 32'(upd_req), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_mode", 32'(lap_mode), 32'd0);
    chk("arst_req", 32'(upd_req), 32'd0);
    chk("arst_count", 32'(lap_count), 32'd0);
    chk("arst_total", 32'(lap_total), 32'd0);
    chk("arst_slot", 32'(upd_slot), 32'd0);
    chk("arst_data", 32'(upd_data), 32'd0);
    chk("arst_disp", 32'(disp), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_mode", 32'(lap_mode), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
